// File: rtl/fir_pkg.sv
// Shared definitions for the FIR datapath: controller state encoding and default sizes
// used by the controller, shift-register and MAC blocks.
package fir_pkg;

  localparam int DEF_WIDTH_DATA = 8;
  localparam int DEF_N_TAPS     = 16;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    SHIFT,
    MAC,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/tap_counter.sv
// Tap index counter for the MAC sweep: counts up when enabled, synchronous
// load-to-zero has priority, tc flags the last tap.
module tap_counter #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          en,
  input  logic          load_zero,
  output logic [AW-1:0] count,
  output logic          tc
);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      count <= '0;
    end else if (load_zero) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = &count;

endmodule

// File: rtl/fir_ctrl.sv
// FIR sequencing controller: accepts one sample, shifts it into the tap history,
// sweeps all taps through the MAC, then holds the result until the consumer takes it.
module fir_ctrl
  import fir_pkg::*;
#(
  parameter int WIDTH_DATA = DEF_WIDTH_DATA,
  parameter int N_TAPS     = DEF_N_TAPS,
  localparam int AW        = $clog2(N_TAPS)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          asr_en,
  output logic          asr_clr,
  output logic [AW-1:0] asr_add,
  output logic [AW-1:0] coef_add,
  output logic          mac_clr,
  output logic          mac_en,
  output logic          warm
);

  localparam int WW = $clog2(N_TAPS + 1);

  if (N_TAPS < 2 || (N_TAPS & (N_TAPS - 1)) != 0 || WIDTH_DATA < 1) begin : g_param_check
    $error("fir_ctrl: N_TAPS must be a power of two >= 2 and WIDTH_DATA >= 1");
  end

  state_t        state, state_next;
  logic [WW-1:0] warm_cnt, warm_cnt_next;
  logic [AW-1:0] tap;
  logic          tap_tc;

  tap_counter #(.AW(AW)) u_tap_counter (
    .clk       (clk),
    .clr       (clr),
    .en        (state == MAC),
    .load_zero ((state != MAC) || tap_tc),
    .count     (tap),
    .tc        (tap_tc)
  );

  // Warm count moves on the same edge that launches the clear/shift strobe.
  always_comb begin
    state_next    = state;
    warm_cnt_next = warm_cnt;
    case (state)
      IDLE: begin
        if (flush) begin
          state_next    = FLUSH;
          warm_cnt_next = '0;
        end else if (in_valid) begin
          state_next = SHIFT;
          if (warm_cnt != WW'(N_TAPS)) begin
            warm_cnt_next = warm_cnt + 1'b1;
          end
        end
      end
      FLUSH:   state_next = IDLE;
      SHIFT:   state_next = MAC;
      MAC:     if (tap_tc) state_next = DRAIN;
      DRAIN:   state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= IDLE;
      warm_cnt  <= '0;
      asr_en    <= 1'b0;
      asr_clr   <= 1'b0;
      mac_en    <= 1'b0;
      mac_clr   <= 1'b0;
      out_valid <= 1'b0;
      warm      <= 1'b0;
    end else begin
      state     <= state_next;
      warm_cnt  <= warm_cnt_next;
      asr_en    <= (state_next == SHIFT);
      asr_clr   <= (state_next == FLUSH);
      mac_en    <= (state_next == MAC);
      mac_clr   <= (state_next == MAC) && (state != MAC);
      out_valid <= (state_next == DONE);
      warm      <= (warm_cnt_next == WW'(N_TAPS));
    end
  end

  assign in_ready = (state == IDLE);
  assign asr_add  = tap;
  assign coef_add = tap;

endmodule

// File: tb/tb_fir_ctrl.sv
// Directed self-checking bench for fir_ctrl with N_TAPS=16: a per-cycle vector
// table for one transaction plus hand-written backpressure, flush, warm-up and reset sequences.
module tb_fir_ctrl;

  typedef struct {
    logic       in_valid;
    logic       flush;
    logic       out_ready;
    logic       in_ready;
    logic       asr_en;
    logic       asr_clr;
    logic       mac_clr;
    logic       mac_en;
    logic       out_valid;
    logic       warm;
    logic [3:0] add;
  } vec_t;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       flush = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       asr_en;
  logic       asr_clr;
  logic [3:0] asr_add;
  logic [3:0] coef_add;
  logic       mac_clr;
  logic       mac_en;
  logic       warm;

  int   errors = 0;
  int   checks = 0;
  vec_t tbl[20];

  fir_ctrl #(.WIDTH_DATA(8), .N_TAPS(16)) dut (
    .clk       (clk),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .asr_en    (asr_en),
    .asr_clr   (asr_clr),
    .asr_add   (asr_add),
    .coef_add  (coef_add),
    .mac_clr   (mac_clr),
    .mac_en    (mac_en),
    .warm      (warm)
  );

  always #5 clk = ~clk;

  // Drive inputs, take one rising edge, and leave the caller 1 time unit after it.
  task automatic applyStimulus(input logic iv, input logic fl, input logic ordy);
    in_valid  = iv;
    flush     = fl;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input vec_t v);
    checkOutput({tag, ".in_ready"},  8'(in_ready),  8'(v.in_ready));
    checkOutput({tag, ".asr_en"},    8'(asr_en),    8'(v.asr_en));
    checkOutput({tag, ".asr_clr"},   8'(asr_clr),   8'(v.asr_clr));
    checkOutput({tag, ".mac_clr"},   8'(mac_clr),   8'(v.mac_clr));
    checkOutput({tag, ".mac_en"},    8'(mac_en),    8'(v.mac_en));
    checkOutput({tag, ".out_valid"}, 8'(out_valid), 8'(v.out_valid));
    checkOutput({tag, ".warm"},      8'(warm),      8'(v.warm));
    checkOutput({tag, ".asr_add"},   8'(asr_add),   8'(v.add));
    checkOutput({tag, ".coef_add"},  8'(coef_add),  8'(v.add));
  endtask

  // Entry i: inputs before edge i (handshake at edge 0), expectations for cycle i+1.
  task automatic runTable(input string tag);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(tbl[i].in_valid, tbl[i].flush, tbl[i].out_ready);
      checkAll($sformatf("%s[%0d]", tag, i), tbl[i]);
    end
  endtask

  task automatic flushTest(input string tag, input logic warm_before);
    checkOutput({tag, ".warm_before"}, 8'(warm), 8'(warm_before));
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput({tag, ".asr_clr"},  8'(asr_clr),  8'd1);
    checkOutput({tag, ".asr_en"},   8'(asr_en),   8'd0);
    checkOutput({tag, ".warm"},     8'(warm),     8'd0);
    checkOutput({tag, ".in_ready"}, 8'(in_ready), 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput({tag, ".asr_clr_one"}, 8'(asr_clr),  8'd0);
    checkOutput({tag, ".idle"},        8'(in_ready), 8'd1);
    checkOutput({tag, ".no_shift1"},   8'(asr_en),   8'd0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput({tag, ".no_shift2"},   8'(asr_en),   8'd0);
    checkOutput({tag, ".warm_after"},  8'(warm),     8'd0);
  endtask

  initial begin
    int c;
    int pulses;
    int last;
    logic found;

    for (int i = 0; i < 20; i++) begin
      c = i + 1;
      tbl[i].in_valid  = (i == 0) || (i == 5);
      tbl[i].flush     = (i == 8);
      tbl[i].out_ready = 1'b1;
      tbl[i].in_ready  = (c == 20);
      tbl[i].asr_en    = (c == 1);
      tbl[i].asr_clr   = 1'b0;
      tbl[i].mac_clr   = (c == 2);
      tbl[i].mac_en    = (c >= 2) && (c <= 17);
      tbl[i].out_valid = (c == 19);
      tbl[i].warm      = 1'b0;
      tbl[i].add       = ((c >= 2) && (c <= 17)) ? 4'(c - 2) : 4'd0;
    end

    #12;
    checkOutput("rst.in_ready",  8'(in_ready),  8'd1);
    checkOutput("rst.asr_en",    8'(asr_en),    8'd0);
    checkOutput("rst.mac_en",    8'(mac_en),    8'd0);
    checkOutput("rst.out_valid", 8'(out_valid), 8'd0);
    checkOutput("rst.asr_add",   8'(asr_add),   8'd0);
    checkOutput("rst.warm",      8'(warm),      8'd0);
    @(negedge clk);
    clr = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("rst.idle", 8'(in_ready), 8'd1);

    runTable("single");

    // Backpressure: result held in DONE while the consumer stalls.
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 18; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("bp.out_valid_rise", 8'(out_valid), 8'd1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("bp[%0d].out_valid", i), 8'(out_valid), 8'd1);
      checkOutput($sformatf("bp[%0d].in_ready", i),  8'(in_ready),  8'd0);
      checkOutput($sformatf("bp[%0d].asr_en", i),    8'(asr_en),    8'd0);
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("bp.release_idle", 8'(in_ready),  8'd1);
    checkOutput("bp.release_ov",   8'(out_valid), 8'd0);

    flushTest("flush0", 1'b0);

    // Warm-up with in_valid held high: one shift every 20 cycles.
    pulses = 0;
    last   = 0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      if (asr_en) begin
        pulses++;
        checkOutput($sformatf("warmup[%0d].warm", pulses), 8'(warm), 8'(pulses >= 16));
        if (pulses > 1) checkOutput($sformatf("warmup[%0d].period", pulses), 8'(cyc - last), 8'd20);
        last = cyc;
      end
    end
    checkOutput("warmup.pulses", 8'(pulses), 8'd20);
    checkOutput("warmup.idle_end", 8'(in_ready), 8'd1);

    flushTest("flush1", 1'b1);

    // Asynchronous reset in the middle of the tap sweep.
    applyStimulus(1'b1, 1'b0, 1'b1);
    found = 1'b0;
    for (int n = 0; n < 30 && !found; n++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      if (mac_en && asr_add == 4'd7) found = 1'b1;
    end
    checkOutput("clr.reached_k7", 8'(found), 8'd1);
    clr = 1'b0;
    #1;
    checkOutput("clr.in_ready", 8'(in_ready), 8'd1);
    checkOutput("clr.mac_en",   8'(mac_en),   8'd0);
    checkOutput("clr.asr_add",  8'(asr_add),  8'd0);
    checkOutput("clr.coef_add", 8'(coef_add), 8'd0);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("clr.held_idle", 8'(in_ready), 8'd1);
    checkOutput("clr.held_noen", 8'(asr_en),   8'd0);
    clr = 1'b1;
    runTable("post_clr");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
